// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared fetch state encoding, NOP and opcode constants
package instr_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Masking keeps every bit of the operand live, so no unused-bit warnings upstream.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// rtl/fetch_fifo2.sv - two-entry in-order FIFO of {pc, instr} pairs with flush
module fetch_fifo2
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [2];
    fetch_entry_t entry_d [2];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         push_ok, pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = entry_q[rd_ptr_q];

    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_ok) begin
                entry_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Entries reset to a NOP at RESET_PC so the head reads cleanly while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q[0] <= '{pc: RESET_PC, instr: NOP_INSTR};
            entry_q[1] <= '{pc: RESET_PC, instr: NOP_INSTR};
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch sequencer feeding a two-entry decode queue
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        code_valid,
    input  logic        code_ready,
    output logic [31:0] code,
    output logic [31:0] code_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;

    logic         req;
    logic         flush;
    logic         pop;
    logic         push;
    logic [2:0]   used;
    logic         credit_ok;

    logic         fifo_full, fifo_empty;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;

    assign code_valid = !fifo_empty;
    assign code       = fifo_head.instr;
    assign code_pc    = fifo_head.pc;
    assign pop        = code_valid && code_ready;

    // Counting this cycle's pop lets a steady stream issue one fetch per cycle.
    assign used      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (used < 3'd2);

    // A response arriving alongside a redirect belongs to the old path.
    assign push       = inflight_q && imem_rvalid && !redirect_valid && (!fifo_full || pop);
    assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

    assign imem_req  = req;
    assign imem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            pc_d    = align_pc(redirect_pc);
            flush   = 1'b1;
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_RUN: begin
                    if (credit_ok) begin
                        req  = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        inflight_d    = req;
        inflight_pc_d = req ? pc_q : inflight_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= align_pc(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo2 #(
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .head_o       (fifo_head)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        code_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req, imem_rvalid, code_valid;
    logic [31:0] imem_addr, imem_rdata, code, code_pc;

    logic        w_req, w_rvalid, w_valid, w_redirect;
    logic [31:0] w_addr, w_rdata, w_code, w_code_pc, w_redirect_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    instr_fetch_queue #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .code_valid     (code_valid),
        .code_ready     (code_ready),
        .code           (code),
        .code_pc        (code_pc)
    );

    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rvalid    (w_rvalid),
        .imem_rdata     (w_rdata),
        .redirect_valid (w_redirect),
        .redirect_pc    (w_redirect_pc),
        .code_valid     (w_valid),
        .code_ready     (code_ready),
        .code           (w_code),
        .code_pc        (w_code_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after each request with word == address.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= imem_addr;
        w_rvalid    <= w_req;
        w_rdata     <= w_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && code_valid && code_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no pop", code_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_code_pc", code_pc, e);
                chk("sb_code", code, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name);
        rst = 1'b1;
        cyc();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    logic [31:0] a_addr [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [31:0] w_exp  [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    initial begin
        rst = 1'b1; code_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        w_redirect = 1'b0; w_redirect_pc = '0;
        repeat (2) cyc();
        chk("rst_code_valid", {31'b0, code_valid}, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_code", code, 32'h0000_0013);
        chk("rst_code_pc", code_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_wrap_code_pc", w_code_pc, 32'hFFFF_FFF8);

        // streaming with decoder always ready, plus the wrapping instance
        code_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("a_req", {31'b0, imem_req}, 32'd1);
            chk("a_addr", imem_addr, a_addr[i]);
            chk("a_valid", {31'b0, code_valid}, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) chk("a_code_pc", code_pc, a_addr[i-2]);
            if (i < 3) chk("wrap_addr", w_addr, w_exp[i]);
            if (i == 2) chk("wrap_code_pc", w_code_pc, 32'hFFFF_FFF8);
        end
        end_test("a_drained");

        // backpressure fills the queue, then reset with a response in flight
        code_ready = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        rst = 1'b0;
        cyc(); cyc();
        chk("b_addr", imem_addr, 32'h4);
        cyc();
        chk("b_req_credit", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("b_hold_valid", {31'b0, code_valid}, 32'd1);
            chk("b_hold_pc", code_pc, 32'h0);
            chk("b_hold_code", code, 32'h0);
            chk("b_full_noreq", {31'b0, imem_req}, 32'd0);
        end
        code_ready = 1'b1;
        #1;
        chk("b_resume_req", {31'b0, imem_req}, 32'd1);
        chk("b_resume_addr", imem_addr, 32'h8);
        cyc();
        chk("b_pc4", code_pc, 32'h4);
        cyc();
        chk("b_pc8", code_pc, 32'h8);
        code_ready = 1'b0;
        rst = 1'b1;
        cyc();
        chk("b_rst_valid", {31'b0, code_valid}, 32'd0);
        chk("b_rst_req", {31'b0, imem_req}, 32'd0);
        chk("b_rst_addr", imem_addr, 32'h0);
        rst = 1'b0;
        cyc();
        chk("b_inflight_dropped", {31'b0, code_valid}, 32'd0);
        end_test("b_drained");

        // redirect to an unaligned target while a response is in flight
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        rst = 1'b0;
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        chk("c_redirect_noreq", {31'b0, imem_req}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        chk("c_flush_valid", {31'b0, code_valid}, 32'd0);
        chk("c_flush_req", {31'b0, imem_req}, 32'd0);
        code_ready = 1'b1;
        cyc();
        chk("c_req", {31'b0, imem_req}, 32'd1);
        chk("c_addr", imem_addr, 32'h100);
        cyc();
        chk("c_addr2", imem_addr, 32'h104);
        cyc();
        chk("c_valid", {31'b0, code_valid}, 32'd1);
        chk("c_code_pc", code_pc, 32'h100);
        cyc();
        cyc();
        end_test("c_drained");

        // redirect coinciding with pop of 0x8, reloaded again during FLUSH
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'h40);
        rst = 1'b0;
        repeat (5) cyc();
        chk("d_head8", code_pc, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        cyc();
        chk("d_flushed", {31'b0, code_valid}, 32'd0);
        redirect_pc = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        chk("d_reload_noreq", {31'b0, imem_req}, 32'd0);
        cyc();
        chk("d_req", {31'b0, imem_req}, 32'd1);
        chk("d_addr", imem_addr, 32'h40);
        cyc();
        chk("d_gap", {31'b0, code_valid}, 32'd0);
        cyc();
        chk("d_code_pc", code_pc, 32'h40);
        cyc();
        end_test("d_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
